counter_monitor: RTL and testbench
==================================

COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 Parameter WIDTH, default 8, width of the observed counter value and load data.
REQ-002 Parameter ERR_LIMIT, default 4, mismatch count at which FAULT is entered.
REQ-003 Ports: one clock; reset is synchronous and active-high; clock port named clk, reset port named rst.
REQ-004 clk  input  1  rising-edge clock, shared with the observed counter.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 obs_out  input  WIDTH  observed counter value.
REQ-007 obs_load  input  1  observed load strobe.
REQ-008 obs_load_data  input  WIDTH  observed load value.
REQ-009 obs_enb  input  1  observed count enable.
REQ-010 obs_mode  input  1  observed direction: 1 = up, 0 = down.
REQ-011 expected  output  WIDTH  current reference-model value.
REQ-012 mismatch  output  1  registered one-cycle flag for each mismatching compare cycle.
REQ-013 err_count  output  8  saturating mismatch counter.
REQ-014 synced  output  1  high while in TRACK or FAULT.
REQ-015 fault  output  1  sticky, high in FAULT.

Function
REQ-016 Model update per rising edge, priority rst > load > enb:
- obs_load=1: model <= obs_load_data.
- else obs_enb=1, obs_mode=1: model <= model+1.
- else obs_enb=1, obs_mode=0: model <= model-1.
- else: model holds.
REQ-017 Arithmetic is modulo 2^WIDTH: all-ones+1 = 0; 0-1 = all-ones.
REQ-018 States: IDLE, TRACK, FAULT.
REQ-019 IDLE: on the first edge with rst=0, model <= obs_out; go to TRACK; no compare in that cycle.
REQ-020 TRACK: compare obs_out against model every cycle. On inequality, mismatch=1 on the next cycle and err_count increments.
REQ-021 Compare uses the model value before the current edge's update; zero-cycle alignment with a registered counter output.
REQ-022 err_count saturates at 255 and never wraps.
REQ-023 TRACK -> FAULT on the edge where err_count reaches ERR_LIMIT. FAULT exits only via rst.
REQ-024 FAULT: model and compare continue; mismatch still pulses; err_count still increments to saturation.
REQ-025 obs_load and obs_enb both high: the load wins, matching the observed counter.
REQ-026 expected equals the model register combinationally.

Reset
REQ-027 rst=1 at any edge, including mid-TRACK or in FAULT, gives next-cycle values:
- state IDLE, model 0, expected 0.
- mismatch 0, err_count 0, synced 0, fault 0.
REQ-028 rst overrides every obs_* input in the same cycle.

Configuration
REQ-029 Macro CNT_MON_RESYNC_EN.
- Defined: on a mismatch cycle, model <= obs_out instead of the REQ-016 update, so one corruption counts once.
- Undefined: the model always follows REQ-016, so an offset counter mismatches every cycle.

Structure
REQ-030 Package cnt_mon_pkg holds the state enumeration (IDLE/TRACK/FAULT), the default WIDTH constant and the err_count width constant.
REQ-031 Sub-module cnt_ref_model holds the model register and the REQ-016/REQ-017 next-value logic. counter_monitor holds the FSM, compare, err_count and outputs.

Verification
REQ-032 Reset, then load 8'hAA, then 5 cycles up with enb=1, then 5 cycles down -> expected AA,AB..AF then AE..AA; mismatch never asserts; err_count=0.
REQ-033 Wrap: load 8'hFF, up 2 cycles -> expected 00, 01; load 8'h00, down 1 cycle -> FF; no mismatch.
REQ-034 Single bad cycle: force obs_out to 8'h55 while model=8'h50 -> one mismatch pulse, err_count=1. With CNT_MON_RESYNC_EN, following correct counting gives no further pulses. Without it, mismatch persists until the values realign.
REQ-035 Fault: inject 4 mismatches (ERR_LIMIT=4) -> fault=1 after the 4th, still 1 after correct traffic; rst -> fault=0, err_count=0, state IDLE.
REQ-036 Priority: obs_load=1, obs_enb=1, obs_mode=1, obs_load_data=8'h10 -> expected 8'h10 next cycle, not 8'h11.
REQ-037 Saturation: 300 consecutive mismatches without the macro -> err_count holds 255.

Source files
------------

// File: rtl/cnt_mon_pkg.sv
// rtl/cnt_mon_pkg.sv - shared types and constants for the counter monitor
package cnt_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int ERR_W     = 8;

  // Error counter sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/cnt_ref_model.sv
// rtl/cnt_ref_model.sv - reference copy of the observed load/up/down counter
module cnt_ref_model
  import cnt_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_en,
  input  logic [WIDTH-1:0] sync_data,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             enb,
  input  logic             mode,
  output logic [WIDTH-1:0] model
);

  logic [WIDTH-1:0] model_nxt;

  // sync_en re-seeds from the observed value and outranks the counter's own controls.
  always_comb begin
    model_nxt = model;
    if (sync_en) begin
      model_nxt = sync_data;
    end else if (load) begin
      model_nxt = load_data;
    end else if (enb) begin
      model_nxt = mode ? model + WIDTH'(1) : model - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      model <= '0;
    end else begin
      model <= model_nxt;
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// rtl/counter_monitor.sv - shadows an up/down counter and flags divergence
// Optional CNT_MON_RESYNC_EN: re-seed the model from obs_out on each mismatch.
module counter_monitor
  import cnt_mon_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ERR_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] obs_out,
  input  logic             obs_load,
  input  logic [WIDTH-1:0] obs_load_data,
  input  logic             obs_enb,
  input  logic             obs_mode,
  output logic [WIDTH-1:0] expected,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic             synced,
  output logic             fault
);

  state_t           state;
  logic [WIDTH-1:0] model;
  logic [ERR_W-1:0] err_inc;
  logic             miscompare;
  logic             sync_en;

  // obs_out is the counter's registered output, so it lines up with the pre-edge model.
  assign miscompare = (state != IDLE) && (obs_out != model);
  assign err_inc    = sat_inc(err_count);

`ifdef CNT_MON_RESYNC_EN
  assign sync_en = (state == IDLE) || miscompare;
`else
  assign sync_en = (state == IDLE);
`endif

  cnt_ref_model #(
    .WIDTH (WIDTH)
  ) u_model (
    .clk       (clk),
    .rst       (rst),
    .sync_en   (sync_en),
    .sync_data (obs_out),
    .load      (obs_load),
    .load_data (obs_load_data),
    .enb       (obs_enb),
    .mode      (obs_mode),
    .model     (model)
  );

  assign expected = model;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mismatch  <= 1'b0;
      err_count <= '0;
      synced    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= TRACK;
          synced   <= 1'b1;
          mismatch <= 1'b0;
        end
        TRACK: begin
          mismatch <= miscompare;
          if (miscompare) begin
            err_count <= err_inc;
            if (int'(err_inc) >= ERR_LIMIT) begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end
        end
        FAULT: begin
          mismatch <= miscompare;
          if (miscompare) begin
            err_count <= err_inc;
          end
        end
        default: begin
          state    <= IDLE;
          mismatch <= 1'b0;
          synced   <= 1'b0;
          fault    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_monitor.sv
// tb/tb_counter_monitor.sv - randomized scoreboard bench for counter_monitor
module tb_counter_monitor;

  localparam int W   = 8;
  localparam int LIM = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] obs_out = '0;
  logic         obs_load = 1'b0;
  logic [W-1:0] obs_load_data = '0;
  logic         obs_enb = 1'b0;
  logic         obs_mode = 1'b0;
  logic [W-1:0] expected;
  logic         mismatch;
  logic [7:0]   err_count;
  logic         synced;
  logic         fault;

  counter_monitor #(.WIDTH(W), .ERR_LIMIT(LIM)) dut (
    .clk           (clk),
    .rst           (rst),
    .obs_out       (obs_out),
    .obs_load      (obs_load),
    .obs_load_data (obs_load_data),
    .obs_enb       (obs_enb),
    .obs_mode      (obs_mode),
    .expected      (expected),
    .mismatch      (mismatch),
    .err_count     (err_count),
    .synced        (synced),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    val;
    int    mis;
    int    err;
    int    syn;
    int    flt;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference: phase 0 = waiting for first capture, 1 = tracking, 2 = faulted.
  int   r_phase = 0;
  int   r_model = 0;
  int   r_err   = 0;
  int   cnt     = 0;
  bit   resync;

  initial begin
`ifdef CNT_MON_RESYNC_EN
    resync = 1'b1;
`else
    resync = 1'b0;
`endif
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, "/expected"},  int'(expected),  e.val);
        check({e.tag, "/mismatch"},  int'(mismatch),  e.mis);
        check({e.tag, "/err_count"}, int'(err_count), e.err);
        check({e.tag, "/synced"},    int'(synced),    e.syn);
        check({e.tag, "/fault"},     int'(fault),     e.flt);
      end
    end
  end

  // One clock of stimulus; gl substitutes glv for the observed counter value.
  task automatic cyc(input bit r, input bit ld, input int ldd, input bit en, input bit md,
                     input bit gl, input int glv, input string tag);
    int   seen;
    int   mis;
    exp_t e;
    seen          = gl ? (glv % 256) : cnt;
    rst           = r;
    obs_load      = ld;
    obs_load_data = W'(ldd);
    obs_enb       = en;
    obs_mode      = md;
    obs_out       = W'(seen);
    @(posedge clk);
    #1;
    mis = 0;
    if (r) begin
      r_phase = 0;
      r_model = 0;
      r_err   = 0;
    end else if (r_phase == 0) begin
      r_phase = 1;
      r_model = seen;
    end else begin
      mis = (seen != r_model) ? 1 : 0;
      if (mis == 1) begin
        r_err = (r_err < 255) ? r_err + 1 : 255;
        if (r_phase == 1 && r_err >= LIM) r_phase = 2;
      end
      if (resync && mis == 1) r_model = seen;
      else if (ld)            r_model = ldd % 256;
      else if (en)            r_model = md ? (r_model + 1) % 256 : (r_model + 255) % 256;
    end
    if (r)       cnt = 0;
    else if (ld) cnt = ldd % 256;
    else if (en) cnt = md ? (cnt + 1) % 256 : (cnt + 255) % 256;
    e.val = r_model;
    e.mis = mis;
    e.err = r_err;
    e.syn = (r_phase != 0) ? 1 : 0;
    e.flt = (r_phase == 2) ? 1 : 0;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic do_rst(input string tag);
    cyc(1, 0, 0, 0, 0, 0, 0, tag);
  endtask
  task automatic idle(input string tag);
    cyc(0, 0, 0, 0, 0, 0, 0, tag);
  endtask
  task automatic load(input int v, input string tag);
    cyc(0, 1, v, 0, 0, 0, 0, tag);
  endtask
  task automatic count(input bit up, input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, up, 0, 0, tag);
  endtask

  initial begin
    do_rst("reset");
    do_rst("reset");
    idle("capture");
    load('hAA, "load_aa");
    count(1, 5, "up_aa");
    count(0, 5, "down_aa");

    load('hFF, "load_ff");
    count(1, 2, "wrap_up");
    load('h00, "load_00");
    count(0, 1, "wrap_down");

    load('h50, "load_50");
    idle("hold_50");
    cyc(0, 0, 0, 0, 0, 1, 'h55, "glitch_55");
    idle("after_glitch");
    cnt = (cnt + 5) % 256;
    count(1, 3, "offset");
    load('h20, "realign");
    idle("realigned");

    do_rst("fault_rst");
    idle("fault_capture");
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 1, cnt ^ 'h0F, "inject");
    load('h30, "post_fault_load");
    count(1, 4, "post_fault");
    do_rst("fault_clear");
    idle("fault_recapture");

    cyc(0, 1, 'h10, 1, 1, 0, 0, "priority");
    idle("priority_hold");

    for (int i = 0; i < 300; i++) cyc(0, 0, 0, 0, 0, 1, r_model ^ 1, "saturate");
    do_rst("sat_clear");
    idle("sat_capture");

    for (int i = 0; i < 400; i++) begin
      bit r, ld, en, md, gl;
      r  = ($urandom_range(63) == 0);
      ld = ($urandom_range(7) == 0);
      en = ($urandom_range(3) != 0);
      md = $urandom_range(1);
      gl = ($urandom_range(15) == 0);
      cyc(r, ld, $urandom_range(255), en, md, gl, $urandom_range(255), "random");
    end

    do_rst("final_rst");
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
